mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one single-port memory between fetch and data ports
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic                clk,
  input  logic                rst_pin,
  // fetch port
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ready,
  output logic [DATA_W-1:0]   if_rdata,
  // data port
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_ready,
  output logic [DATA_W-1:0]   d_rdata,
  // shared memory
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int BE_W  = DATA_W / 8;
  // Counter holds MEM_LAT-1 down to 0; keep at least one bit for MEM_LAT=1.
  localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [BE_W-1:0]   lat_be;
  logic              lat_we;
  logic              win_d;        // 1: data port owns the current access
  logic              last_grant_d; // 1: data port was granted most recently
  logic              pick_d;

  // Round-robin pick: data wins alone, or on contention when fetch went last.
  always_comb begin
    pick_d = d_req & (~if_req | ~last_grant_d);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_pin) begin
    if (!rst_pin) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: one ISSUE cycle, MEM_LAT WAIT cycles, one RESP cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (if_req || d_req) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latching, wait countdown and read-data capture.
  always_ff @(posedge clk or negedge rst_pin) begin
    if (!rst_pin) begin
      cnt_q        <= '0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_be       <= '0;
      lat_we       <= 1'b0;
      win_d        <= 1'b0;
      last_grant_d <= 1'b0;
      if_rdata     <= '0;
      d_rdata      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (if_req || d_req) begin
            win_d        <= pick_d;
            last_grant_d <= pick_d;
            if (pick_d) begin
              lat_addr  <= d_addr;
              lat_wdata <= d_wdata;
              lat_be    <= d_be;
              lat_we    <= d_we;
            end else begin
              // Fetches are always full-word reads.
              lat_addr  <= if_addr;
              lat_wdata <= '0;
              lat_be    <= '1;
              lat_we    <= 1'b0;
            end
          end
        end
        ISSUE: cnt_q <= CNT_W'(MEM_LAT - 1);
        WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (!lat_we) begin
            if (win_d) d_rdata  <= mem_rdata;
            else       if_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory strobes only in ISSUE; address/data/strobes come from the latched request.
  always_comb begin
    mem_en    = (state_q == ISSUE);
    mem_we    = (state_q == ISSUE) & lat_we;
    mem_addr  = lat_addr;
    mem_wdata = lat_wdata;
    mem_be    = lat_be;
    if_ready  = (state_q == RESP) & ~win_d;
    d_ready   = (state_q == RESP) &  win_d;
    busy      = (state_q != IDLE);
  end

endmodule
